control_multiciclo: RTL and testbench

Multicycle control unit for the RV32I core. It replaces single-cycle decoding with a state machine that sequences fetch, decode, execute, memory and write-back. Memory access uses a request/ready handshake with bounded wait states, and the unit flags illegal opcodes and bus timeouts. It sits between the instruction register (IR) and the datapath, and drives the same control fields the datapath already consumes, plus the PC and IR write enables.

---
 rtl/control_pkg.sv | 49 ++++
 rtl/control.sv | 75 +++++++
 rtl/control_multiciclo.sv | 205 ++++++++++++++++++++
 tb/tb_control_multiciclo.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared encodings for the RV32I multicycle control unit: FSM states,
// major opcodes, ALU operation classes and operand-A select codes.
package control_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  localparam int unsigned OPCODE_W = 7;

  localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_R      = 3'b000;
  localparam logic [2:0] ALU_I      = 3'b001;
  localparam logic [2:0] ALU_LOAD   = 3'b010;
  localparam logic [2:0] ALU_STORE  = 3'b011;
  localparam logic [2:0] ALU_BRANCH = 3'b100;
  localparam logic [2:0] ALU_LUI    = 3'b101;
  localparam logic [2:0] ALU_AUIPC  = 3'b110;
  localparam logic [2:0] ALU_JAL    = 3'b111;

  localparam logic [1:0] SEL_PC   = 2'b00;
  localparam logic [1:0] SEL_ZERO = 2'b01;
  localparam logic [1:0] SEL_REG  = 2'b10;

  // True for every opcode the datapath knows how to execute.
  function automatic logic is_known_opcode(input logic [OPCODE_W-1:0] op);
    logic known;
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL: known = 1'b1;
      default:                                                           known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/control.sv
// Single-cycle opcode decoder; produces the raw control fields for one opcode.
// Memory strobes are active-low; unknown opcodes decode to all-inactive fields.
module control
  import control_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       branch,
  output logic       mem_read_n,
  output logic       mem_write_n,
  output logic       mem_reg,
  output logic [2:0] alu_op,
  output logic       alu_src,
  output logic       reg_write,
  output logic [1:0] auipc_lui
);

  always_comb begin
    branch      = 1'b0;
    mem_read_n  = 1'b1;
    mem_write_n = 1'b1;
    mem_reg     = 1'b0;
    alu_op      = ALU_R;
    alu_src     = 1'b0;
    reg_write   = 1'b0;
    auipc_lui   = SEL_REG;
    case (opcode)
      OP_R: begin
        alu_op    = ALU_R;
        reg_write = 1'b1;
      end
      OP_I: begin
        alu_op    = ALU_I;
        alu_src   = 1'b1;
        reg_write = 1'b1;
      end
      OP_LOAD: begin
        alu_op     = ALU_LOAD;
        alu_src    = 1'b1;
        mem_read_n = 1'b0;
        mem_reg    = 1'b1;
        reg_write  = 1'b1;
      end
      OP_STORE: begin
        alu_op      = ALU_STORE;
        alu_src     = 1'b1;
        mem_write_n = 1'b0;
      end
      OP_BRANCH: begin
        alu_op = ALU_BRANCH;
        branch = 1'b1;
      end
      OP_LUI: begin
        alu_op    = ALU_LUI;
        alu_src   = 1'b1;
        reg_write = 1'b1;
        auipc_lui = SEL_ZERO;
      end
      OP_AUIPC: begin
        alu_op    = ALU_AUIPC;
        alu_src   = 1'b1;
        reg_write = 1'b1;
        auipc_lui = SEL_PC;
      end
      OP_JAL: begin
        alu_op    = ALU_JAL;
        alu_src   = 1'b1;
        reg_write = 1'b1;
        branch    = 1'b1;
        auipc_lui = SEL_PC;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle RV32I control FSM: fetch/decode/exec/mem/wb sequencing with a
// bounded memory handshake, sticky illegal-opcode and bus-timeout flags.
module control_multiciclo
  import control_pkg::*;
#(
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [6:0]         OPCODE,
  input  logic               MEM_READY,
  output logic               MEM_REQ,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               BRANCH,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemReg,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               ALUScr,
  output logic               RegWrite,
  output logic [1:0]         AuipcLui,
  output logic               INSTR_DONE,
  output logic               ILLEGAL,
  output logic               BUS_ERR,
  output logic [CNT_W-1:0]   RETIRED
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_e             state_q,   state_d;
  logic [6:0]         opcode_q,  opcode_d;
  logic [WAIT_W-1:0]  wait_q,    wait_d;
  logic               illegal_q, illegal_d;
  logic               bus_err_q, bus_err_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  logic       retire_c;
  logic       timed_out_c;
  logic       is_load_c, is_store_c, is_branch_c;

  logic       dec_branch, dec_mem_read_n, dec_mem_write_n, dec_mem_reg;
  logic [2:0] dec_alu_op;
  logic       dec_alu_src, dec_reg_write;
  logic [1:0] dec_auipc_lui;

  control u_control (
    .opcode      (opcode_q),
    .branch      (dec_branch),
    .mem_read_n  (dec_mem_read_n),
    .mem_write_n (dec_mem_write_n),
    .mem_reg     (dec_mem_reg),
    .alu_op      (dec_alu_op),
    .alu_src     (dec_alu_src),
    .reg_write   (dec_reg_write),
    .auipc_lui   (dec_auipc_lui)
  );

  assign is_load_c   = (opcode_q == OP_LOAD);
  assign is_store_c  = (opcode_q == OP_STORE);
  assign is_branch_c = (opcode_q == OP_BRANCH);

  // Bus error when the last allowed wait cycle also goes unanswered.
  assign timed_out_c = !MEM_READY && (wait_q == WAIT_LAST);

  // Next-state, wait counter, sticky flags and retire accounting.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    wait_d    = '0;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    retire_c  = 1'b0;

    if ((state_q == S_FETCH || state_q == S_MEM) && !MEM_READY) begin
      wait_d = wait_q + WAIT_W'(1);
    end

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (MEM_READY) begin
          state_d = S_DECODE;
        end else if (timed_out_c) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        opcode_d = OPCODE;
        if (is_known_opcode(OPCODE)) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_load_c || is_store_c) begin
          state_d = S_MEM;
        end else if (is_branch_c) begin
          state_d  = S_FETCH;
          retire_c = 1'b1;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (MEM_READY) begin
          if (is_store_c) begin
            state_d  = S_FETCH;
            retire_c = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end else if (timed_out_c) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_WB: begin
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase

    retired_d = retire_c ? retired_q + CNT_W'(1) : retired_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      retired_q <= retired_d;
    end
  end

  // Moore outputs from state and latched opcode; IRWrite and the store
  // retire pulse follow the memory handshake of the current cycle.
  always_comb begin
    MEM_REQ    = 1'b0;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    BRANCH     = 1'b0;
    MemRead    = 1'b1;
    MemWrite   = 1'b1;
    MemReg     = 1'b0;
    ALUOp      = '0;
    ALUScr     = 1'b0;
    RegWrite   = 1'b0;
    AuipcLui   = SEL_REG;
    INSTR_DONE = 1'b0;

    case (state_q)
      S_FETCH: begin
        MEM_REQ = 1'b1;
        MemRead = 1'b0;
        IRWrite = MEM_READY;
      end
      S_EXEC: begin
        ALUOp      = ALUOP_W'(dec_alu_op);
        ALUScr     = dec_alu_src;
        AuipcLui   = dec_auipc_lui;
        BRANCH     = dec_branch;
        PCWrite    = is_branch_c;
        INSTR_DONE = is_branch_c;
      end
      S_MEM: begin
        MEM_REQ    = 1'b1;
        MemRead    = dec_mem_read_n;
        MemWrite   = dec_mem_write_n;
        PCWrite    = is_store_c && MEM_READY;
        INSTR_DONE = is_store_c && MEM_READY;
      end
      S_WB: begin
        RegWrite   = dec_reg_write;
        MemReg     = dec_mem_reg;
        BRANCH     = dec_branch;
        PCWrite    = 1'b1;
        INSTR_DONE = 1'b1;
      end
      default: ;
    endcase
  end

  assign ILLEGAL = illegal_q;
  assign BUS_ERR = bus_err_q;
  assign RETIRED = retired_q;

endmodule

// File: tb/tb_control_multiciclo.sv
// Directed bench for control_multiciclo: per-cycle output vectors for each
// instruction class, illegal opcode trap, bus timeout and mid-instruction reset.
module tb_control_multiciclo;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [6:0]  OPCODE;
  logic        MEM_READY;
  logic        MEM_REQ, PCWrite, IRWrite, BRANCH, MemRead, MemWrite, MemReg;
  logic [2:0]  ALUOp;
  logic        ALUScr, RegWrite;
  logic [1:0]  AuipcLui;
  logic        INSTR_DONE, ILLEGAL, BUS_ERR;
  logic [31:0] RETIRED;

  control_multiciclo #(
    .ALUOP_W (3),
    .TIMEOUT (15),
    .CNT_W   (32)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .OPCODE     (OPCODE),
    .MEM_READY  (MEM_READY),
    .MEM_REQ    (MEM_REQ),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .BRANCH     (BRANCH),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .MemReg     (MemReg),
    .ALUOp      (ALUOp),
    .ALUScr     (ALUScr),
    .RegWrite   (RegWrite),
    .AuipcLui   (AuipcLui),
    .INSTR_DONE (INSTR_DONE),
    .ILLEGAL    (ILLEGAL),
    .BUS_ERR    (BUS_ERR),
    .RETIRED    (RETIRED)
  );

  always #5 CLK = ~CLK;

  localparam logic [6:0] OPC_ADD = 7'b0110011;
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_BAD = 7'b1111111;

  int n_tests = 0;
  int n_fail  = 0;

  // {MEM_REQ, IRWrite, PCWrite, BRANCH, MemRead, MemWrite, MemReg, ALUScr, RegWrite, INSTR_DONE, ALUOp, AuipcLui}
  logic [14:0] obs;
  assign obs = {MEM_REQ, IRWrite, PCWrite, BRANCH, MemRead, MemWrite, MemReg,
                ALUScr, RegWrite, INSTR_DONE, ALUOp, AuipcLui};

  logic [14:0] v_idle, v_frdy, v_fwait, v_wb, v_wb_ld, v_wb_jal;
  logic [14:0] v_mem_ld, v_mem_st_wait, v_mem_st_rdy;
  logic [14:0] v_ex_ld, v_ex_st, v_ex_b, v_ex_lui, v_ex_jal;

  function automatic logic [14:0] ov(input logic req, input logic irw, input logic pcw,
                                     input logic br, input logic rd, input logic wr,
                                     input logic mr, input logic asrc, input logic rw,
                                     input logic dn, input logic [2:0] op, input logic [1:0] al);
    return {req, irw, pcw, br, rd, wr, mr, asrc, rw, dn, op, al};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [14:0] exp);
    check(tag, 32'(obs), 32'(exp));
  endtask

  // Advance one cycle, drive MEM_READY for it, then settle before sampling.
  task automatic step(input logic rdy);
    @(posedge CLK);
    #1;
    MEM_READY = rdy;
    #2;
  endtask

  // Hold RESET across one edge; returns in the IDLE cycle that follows.
  task automatic do_reset();
    RESET     = 1'b1;
    MEM_READY = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    #2;
  endtask

  initial begin
    //                 req irw pcw br rd wr mr as rw dn  op      al
    v_idle        = ov(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 3'b000, 2'b10);
    v_frdy        = ov(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 3'b000, 2'b10);
    v_fwait       = ov(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3'b000, 2'b10);
    v_wb          = ov(0, 0, 1, 0, 1, 1, 0, 0, 1, 1, 3'b000, 2'b10);
    v_wb_ld       = ov(0, 0, 1, 0, 1, 1, 1, 0, 1, 1, 3'b000, 2'b10);
    v_wb_jal      = ov(0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 3'b000, 2'b10);
    v_mem_ld      = ov(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3'b000, 2'b10);
    v_mem_st_wait = ov(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3'b000, 2'b10);
    v_mem_st_rdy  = ov(1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 3'b000, 2'b10);
    v_ex_ld       = ov(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 3'b010, 2'b10);
    v_ex_st       = ov(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 3'b011, 2'b10);
    v_ex_b        = ov(0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 3'b100, 2'b10);
    v_ex_lui      = ov(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 3'b101, 2'b01);
    v_ex_jal      = ov(0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 3'b111, 2'b00);

    RESET     = 1'b1;
    MEM_READY = 1'b0;
    OPCODE    = OPC_ADD;
    step(1'b0);
    expect_out("rst_outputs", v_idle);
    check("rst_retired", RETIRED, 32'd0);
    check("rst_illegal", 32'(ILLEGAL), 32'd0);
    check("rst_bus_err", 32'(BUS_ERR), 32'd0);
    do_reset();
    expect_out("idle_after_rst", v_idle);

    // add, zero-wait: F D E W
    step(1'b1); expect_out("add_fetch", v_frdy);
    step(1'b0); expect_out("add_decode", v_idle);
    step(1'b0); expect_out("add_exec", v_idle);
    check("add_exec_aluop", 32'(ALUOp), 32'd0);
    step(1'b0); expect_out("add_wb", v_wb);

    // lw with 3 wait cycles in MEM: retire in cycle 8
    OPCODE = OPC_LW;
    step(1'b1); expect_out("lw_fetch", v_frdy);
    check("add_retired", RETIRED, 32'd1);
    step(1'b0); expect_out("lw_decode", v_idle);
    step(1'b0); expect_out("lw_exec", v_ex_ld);
    for (int i = 0; i < 3; i++) begin
      step(1'b0); expect_out("lw_mem_wait", v_mem_ld);
    end
    step(1'b1); expect_out("lw_mem_ready", v_mem_ld);
    step(1'b0); expect_out("lw_wb", v_wb_ld);

    // sw, zero-wait: F D E M
    OPCODE = OPC_SW;
    step(1'b1); expect_out("sw_fetch", v_frdy);
    check("lw_retired", RETIRED, 32'd2);
    step(1'b0); expect_out("sw_decode", v_idle);
    step(1'b0); expect_out("sw_exec", v_ex_st);
    step(1'b1); expect_out("sw_mem", v_mem_st_rdy);

    // beq: F D E, retire in EXEC
    OPCODE = OPC_BEQ;
    step(1'b1); expect_out("beq_fetch", v_frdy);
    check("sw_retired", RETIRED, 32'd3);
    step(1'b0); expect_out("beq_decode", v_idle);
    step(1'b0); expect_out("beq_exec", v_ex_b);

    // lui
    OPCODE = OPC_LUI;
    step(1'b1); expect_out("lui_fetch", v_frdy);
    check("beq_retired", RETIRED, 32'd4);
    step(1'b0); expect_out("lui_decode", v_idle);
    step(1'b0); expect_out("lui_exec", v_ex_lui);
    step(1'b0); expect_out("lui_wb", v_wb);

    // jal
    OPCODE = OPC_JAL;
    step(1'b1); expect_out("jal_fetch", v_frdy);
    check("lui_retired", RETIRED, 32'd5);
    step(1'b0); expect_out("jal_decode", v_idle);
    step(1'b0); expect_out("jal_exec", v_ex_jal);
    step(1'b0); expect_out("jal_wb", v_wb_jal);

    // sw aborted by RESET while waiting in MEM
    OPCODE = OPC_SW;
    step(1'b1); expect_out("swr_fetch", v_frdy);
    check("jal_retired", RETIRED, 32'd6);
    step(1'b0); expect_out("swr_decode", v_idle);
    step(1'b0); expect_out("swr_exec", v_ex_st);
    step(1'b0); expect_out("swr_mem_wait", v_mem_st_wait);
    do_reset();
    expect_out("swr_after_reset", v_idle);
    check("swr_retired", RETIRED, 32'd0);
    OPCODE = OPC_ADD;
    step(1'b1); expect_out("post_rst_fetch", v_frdy);
    step(1'b0); expect_out("post_rst_decode", v_idle);
    step(1'b0); expect_out("post_rst_exec", v_idle);
    step(1'b0); expect_out("post_rst_wb", v_wb);

    // fetch answered on the 15th request cycle: completes without error
    for (int i = 1; i < 15; i++) begin
      step(1'b0); expect_out("late_fetch_wait", v_fwait);
    end
    step(1'b1); expect_out("late_fetch_ready", v_frdy);
    check("late_no_bus_err", 32'(BUS_ERR), 32'd0);
    step(1'b0); expect_out("late_decode", v_idle);
    step(1'b0); expect_out("late_exec", v_idle);
    step(1'b0); expect_out("late_wb", v_wb);

    // illegal opcode traps after DECODE and stays idle
    OPCODE = OPC_BAD;
    step(1'b1); expect_out("ill_fetch", v_frdy);
    check("late_retired", RETIRED, 32'd2);
    step(1'b0); expect_out("ill_decode", v_idle);
    check("ill_before_trap", 32'(ILLEGAL), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step(1'(i % 2));
      expect_out("ill_trap_idle", v_idle);
      check("ill_flag", 32'(ILLEGAL), 32'd1);
      check("ill_retired", RETIRED, 32'd2);
    end

    // bus timeout in FETCH: BUS_ERR 15 cycles after request start
    OPCODE = OPC_ADD;
    do_reset();
    expect_out("to_idle", v_idle);
    check("to_illegal_cleared", 32'(ILLEGAL), 32'd0);
    for (int i = 1; i <= 15; i++) begin
      step(1'b0);
      expect_out("to_fetch_wait", v_fwait);
      check("to_no_err_yet", 32'(BUS_ERR), 32'd0);
    end
    step(1'b0);
    expect_out("to_trap_idle", v_idle);
    check("to_bus_err", 32'(BUS_ERR), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      expect_out("to_trap_hold", v_idle);
      check("to_bus_err_sticky", 32'(BUS_ERR), 32'd1);
      check("to_retired", RETIRED, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
